// File: rtl/hspi_tx_arbiter.sv
// hspi_tx_arbiter: round-robin arbiter that shares one HSPI TX engine among
// N_REQ packet sources and steers the engine's RAM read port to the winner.
// Ports: clk, rstn (async, active low); req/done/pending per source;
// err on timeout; gnt_vld/gnt_id grant status; tx_act engine start pulse;
// hspi_busy engine HTREQ; ram_addr/ram_rdata engine RAM port;
// src_addr/src_rdata per-source buffer port (source i at [i*DATA_W +: DATA_W]).
// Optional: define HSPI_ARB_PRIO_EN to give source 0 strict priority.
module hspi_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 65535,
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [N_REQ-1:0]        req,
   output logic [N_REQ-1:0]        done,
   output logic                    err,
   output logic                    gnt_vld,
   output logic [2:0]              gnt_id,
   output logic [N_REQ-1:0]        pending,
   output logic                    tx_act,
   input  logic                    hspi_busy,
   input  logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       ram_rdata,
   output logic [ADDR_W-1:0]       src_addr,
   input  logic [N_REQ*DATA_W-1:0] src_rdata
);

   localparam int TW     = $clog2(TIMEOUT_CYC + 1);
   localparam int GW     = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
   localparam int GAP_M1 = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_M1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WSTART,
      S_WEND,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] pend_q, pend_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             err_q, err_d;
   logic [2:0]       gnt_q, gnt_d;
   logic [2:0]       last_q, last_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [GW-1:0]    gap_q, gap_d;

   logic             hi_vld, lo_vld, win_vld;
   logic [2:0]       hi_id, lo_id, win_id;
   logic [N_REQ-1:0] gnt_oh;

   // Round-robin pick: lowest pending index above last_q, else the
   // lowest pending index at or below it (the wrap-around).
   always_comb begin
      hi_vld = 1'b0;
      hi_id  = '0;
      lo_vld = 1'b0;
      lo_id  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (pend_q[i] && (3'(i) > last_q)) begin
            hi_vld = 1'b1;
            hi_id  = 3'(i);
         end
         if (pend_q[i] && (3'(i) <= last_q)) begin
            lo_vld = 1'b1;
            lo_id  = 3'(i);
         end
      end
      win_vld = hi_vld | lo_vld;
      win_id  = hi_vld ? hi_id : lo_id;
`ifdef HSPI_ARB_PRIO_EN
      if (pend_q[0]) begin
         win_vld = 1'b1;
         win_id  = '0;
      end
`endif
   end

   always_comb begin
      gnt_oh = '0;
      for (int i = 0; i < N_REQ; i++)
         gnt_oh[i] = (gnt_q == 3'(i));
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      done_d  = '0;
      err_d   = 1'b0;
      tmo_d   = '0;
      gap_d   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               gnt_d   = win_id;
`ifdef HSPI_ARB_PRIO_EN
               // Source 0 grants leave the rotation among 1..N-1 intact.
               if (win_id != 3'd0)
                  last_d = win_id;
`else
               last_d  = win_id;
`endif
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: state_d = S_WSTART;
         S_WSTART: begin
            if (hspi_busy) begin
               state_d = S_WEND;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_GAP;
               done_d  = gnt_oh;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WEND: begin
            if (!hspi_busy) begin
               state_d = S_GAP;
               done_d  = gnt_oh;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_GAP;
               done_d  = gnt_oh;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_GAP: begin
            if ((GAP_CYC == 0) || (gap_q == GAP_LAST))
               state_d = S_IDLE;
            else
               gap_d = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A new request in the completion cycle must not be lost.
   assign pend_d = (pend_q & ~done_q) | req;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         gnt_q   <= '0;
         last_q  <= 3'(N_REQ - 1);
         tmo_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         err_q   <= err_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         tmo_q   <= tmo_d;
         gap_q   <= gap_d;
      end
   end

   assign tx_act  = (state_q == S_LAUNCH);
   assign gnt_vld = (state_q == S_LAUNCH) ||
                    (state_q == S_WSTART) ||
                    (state_q == S_WEND);
   assign gnt_id  = gnt_q;
   assign pending = pend_q;
   assign done    = done_q;
   assign err     = err_q;
   assign src_addr = ram_addr;

   // Zero-latency read mux keeps the engine's RAM timing unchanged.
   always_comb begin
      ram_rdata = '0;
      for (int i = 0; i < N_REQ; i++)
         if (gnt_vld && (gnt_q == 3'(i)))
            ram_rdata = src_rdata[i*DATA_W +: DATA_W];
   end

endmodule

// File: tb/tb_hspi_tx_arbiter.sv
// tb_hspi_tx_arbiter: directed bench with grant/done scoreboard queues.
// Checks latency, round-robin order, gap, timeouts, mux and async reset.
module tb_hspi_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 16;
   localparam int TMO = 120;
   localparam int AW  = 9;
   localparam int DW  = 32;

   logic            clk = 1'b0;
   logic            rstn;
   logic [N-1:0]    req;
   logic [N-1:0]    done;
   logic            err;
   logic            gnt_vld;
   logic [2:0]      gnt_id;
   logic [N-1:0]    pending;
   logic            tx_act;
   logic            hspi_busy;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_rdata;
   logic [AW-1:0]   src_addr;
   logic [N*DW-1:0] src_rdata;

   int checks   = 0;
   int failures = 0;

   int         exp_gnt[$];
   logic [4:0] exp_done[$];

   hspi_tx_arbiter #(
      .N_REQ(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO),
      .ADDR_W(AW), .DATA_W(DW)
   ) dut (
      .clk(clk), .rstn(rstn), .req(req), .done(done), .err(err),
      .gnt_vld(gnt_vld), .gnt_id(gnt_id), .pending(pending),
      .tx_act(tx_act), .hspi_busy(hspi_busy), .ram_addr(ram_addr),
      .ram_rdata(ram_rdata), .src_addr(src_addr), .src_rdata(src_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_launch(output int lat, output int g);
      lat = 0;
      g   = -1;
      while (tx_act !== 1'b1 && lat < 300) begin
         tick();
         lat++;
      end
      if (tx_act !== 1'b1) begin
         chk("launch_wait", {31'b0, tx_act}, 32'd1);
      end else if (exp_gnt.size() > 0) begin
         g = exp_gnt.pop_front();
         chk("gnt_id", {29'b0, gnt_id}, g);
      end
   endtask

   task automatic check_done();
      logic [4:0] e;
      e = (exp_done.size() > 0) ? exp_done.pop_front() : 5'h1f;
      chk("done", {28'b0, done}, {28'b0, e[3:0]});
      chk("err", {31'b0, err}, {31'b0, e[4]});
   endtask

   task automatic xfer(input int blen, output int lat);
      int g;
      wait_launch(lat, g);
      tick();
      chk("tx_act_1cyc", {31'b0, tx_act}, 32'd0);
      chk("vld_wstart", {31'b0, gnt_vld}, 32'd1);
      hspi_busy = 1'b1;
      repeat (blen) tick();
      chk("rdata_wend", ram_rdata, 32'hA5A5_0000 | g);
      hspi_busy = 1'b0;
      tick();
      check_done();
   endtask

   initial begin
      int lat, g, n;
      rstn      = 1'b0;
      req       = '0;
      hspi_busy = 1'b0;
      ram_addr  = '0;
      for (int i = 0; i < N; i++)
         src_rdata[i*DW +: DW] = 32'hA5A5_0000 | i;
      tick();
      tick();
      chk("rst_tx_act", {31'b0, tx_act}, 32'd0);
      chk("rst_gnt_vld", {31'b0, gnt_vld}, 32'd0);
      chk("rst_done", {28'b0, done}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_pending", {28'b0, pending}, 32'd0);
      chk("rst_gnt_id", {29'b0, gnt_id}, 32'd0);
      chk("rst_rdata", ram_rdata, 32'd0);
      ram_addr = 9'h1A5;
      #1;
      chk("src_addr", {23'b0, src_addr}, 32'h1A5);
      rstn = 1'b1;
      tick();

      // single request, latency 2
      req = 4'b0100;
      exp_gnt.push_back(2);
      exp_done.push_back({1'b0, 4'b0100});
      tick();
      req = '0;
      chk("pend_set", {28'b0, pending}, 32'h4);
      chk("lat_c1", {31'b0, tx_act}, 32'd0);
      tick();
      chk("lat_c2", {31'b0, tx_act}, 32'd1);
      xfer(100, lat);
      chk("pend_at_done", {28'b0, pending}, 32'h4);
      chk("rdata_gap", ram_rdata, 32'd0);

      // gap enforcement, grant 3 with mux
      req = 4'b1000;
      exp_gnt.push_back(3);
      exp_done.push_back({1'b0, 4'b1000});
      tick();
      req = '0;
      chk("pend_clr_set", {28'b0, pending}, 32'h8);
      ram_addr = 9'h0F3;
      #1;
      chk("src_addr2", {23'b0, src_addr}, 32'h0F3);
      xfer(10, lat);
      chk("gap_lat", lat, GAP);

      // fairness
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         exp_gnt.push_back(i);
         exp_done.push_back({1'b0, 4'(1 << i)});
      end
      tick();
      req = '0;
      repeat (4) xfer(10, lat);
      req = 4'b1001;
      exp_gnt.push_back(0);
      exp_done.push_back({1'b0, 4'b0001});
      exp_gnt.push_back(3);
      exp_done.push_back({1'b0, 4'b1000});
      tick();
      req = '0;
      repeat (2) xfer(10, lat);

      // timeout in WAIT_START
      req = 4'b0010;
      exp_gnt.push_back(1);
      exp_done.push_back({1'b1, 4'b0010});
      tick();
      req = '0;
      wait_launch(lat, g);
      tick();
      n = 0;
      while (done === '0 && n < 400) begin
         tick();
         n++;
      end
      chk("tmo_ws_cyc", n, TMO);
      check_done();
      tick();
      chk("tmo_pend_clr", {28'b0, pending}, 32'd0);

      // request collides with done
      req = 4'b0010;
      exp_gnt.push_back(1);
      exp_done.push_back({1'b0, 4'b0010});
      tick();
      req = '0;
      xfer(5, lat);
      req = 4'b0010;
      exp_gnt.push_back(1);
      exp_done.push_back({1'b0, 4'b0010});
      tick();
      req = '0;
      chk("collide_pend", {28'b0, pending}, 32'h2);
      xfer(5, lat);
      chk("collide_gap", lat, GAP);

      // timeout in WAIT_END
      req = 4'b0100;
      exp_gnt.push_back(2);
      exp_done.push_back({1'b1, 4'b0100});
      tick();
      req = '0;
      wait_launch(lat, g);
      tick();
      hspi_busy = 1'b1;
      tick();
      n = 0;
      while (done === '0 && n < 400) begin
         tick();
         n++;
      end
      chk("tmo_we_cyc", n, TMO);
      hspi_busy = 1'b0;
      check_done();

      // async reset during WAIT_END
      req = 4'b0100;
      exp_gnt.push_back(2);
      tick();
      req = '0;
      wait_launch(lat, g);
      tick();
      hspi_busy = 1'b1;
      repeat (3) tick();
      chk("pre_rst_vld", {31'b0, gnt_vld}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_tx_act", {31'b0, tx_act}, 32'd0);
      chk("mid_rst_vld", {31'b0, gnt_vld}, 32'd0);
      chk("mid_rst_pend", {28'b0, pending}, 32'd0);
      chk("mid_rst_done", {28'b0, done}, 32'd0);
      hspi_busy = 1'b0;
      tick();
      tick();
      chk("rst_hold_err", {31'b0, err}, 32'd0);
      rstn = 1'b1;
      req  = 4'b1001;
      exp_gnt.push_back(0);
      exp_done.push_back({1'b0, 4'b0001});
      exp_gnt.push_back(3);
      exp_done.push_back({1'b0, 4'b1000});
      tick();
      req = '0;
      chk("post_rst_c1", {31'b0, tx_act}, 32'd0);
      tick();
      chk("post_rst_c2", {31'b0, tx_act}, 32'd1);
      xfer(3, lat);
      xfer(3, lat);

      chk("sb_empty", exp_gnt.size() + exp_done.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hspi_tx_arbiter.md
Name: hspi_tx_arbiter

Overview:
- Shares the single HSPI transmit engine between N_REQ packet sources. Requests are queued, a round-robin winner is picked, and the engine gets a one-cycle `tx_act` start pulse.
- Tracks transfer start and end by watching the engine's HTREQ output. Enforces an inter-packet gap and a watchdog timeout.
- Steers the engine's RAM read port to the granted source's buffer.
- Sits between the per-source packet buffers and the HSPI TX engine, in the `clk` domain.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- GAP_CYC, 16, idle clk cycles between packets (0 allowed)
- TIMEOUT_CYC, 65535, max clk cycles spent in WAIT_START or in WAIT_END
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, RAM data width

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req  in  N_REQ  one-cycle request pulse per source; sets pending[i]
- done  out  N_REQ  one-cycle completion pulse to the granted source
- err  out  1  one-cycle pulse, coincident with done, when the transfer timed out
- gnt_vld  out  1  a grant is active (LAUNCH..WAIT_END)
- gnt_id  out  3  index of the current or last grant
- pending  out  N_REQ  queued-request register
- tx_act  out  1  start pulse to the HSPI engine
- hspi_busy  in  1  engine HTREQ; high while a packet is being sent
- ram_addr  in  ADDR_W  read address from the engine
- ram_rdata  out  DATA_W  read data to the engine
- src_addr  out  ADDR_W  ram_addr forwarded to all sources
- src_rdata  in  N_REQ*DATA_W  concatenated per-source read data; source i at [i*DATA_W +: DATA_W]

Behaviour:
- Reset values: all outputs 0; pending=0; state IDLE; last_gnt=N_REQ-1, so source 0 wins first.
- The reset is asynchronous. Asserting it mid-transfer drops tx_act and gnt_vld immediately, with no done or err pulse.
- pending[i] is set on req[i]. It clears in the cycle done[i] is high. If req[i] and done[i] occur in the same cycle, set wins.
- FSM:
  - IDLE: if pending≠0, pick the first set bit scanning from last_gnt+1 upward with wrap. Register it into gnt_id and last_gnt, then go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: tx_act=1 for exactly this cycle; go to WAIT_START.
  - WAIT_START: on hspi_busy=1, go to WAIT_END. If the timeout counter reaches TIMEOUT_CYC-1, pulse done[gnt_id] and err, then go to GAP.
  - WAIT_END: on hspi_busy=0, pulse done[gnt_id] with err=0, then go to GAP. On timeout, pulse done and err, then go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE. When GAP_CYC=0, go straight to IDLE in the next cycle.
- done and err are registered; they assert in the first cycle of GAP.
- Latency: a req pulse at cycle 0 gives tx_act at cycle 2.
- The timeout counter clears on every state entry. It is width clog2(TIMEOUT_CYC+1).
- The gap counter is width clog2(GAP_CYC+1), with a minimum of 1.
- gnt_vld=1 in LAUNCH, WAIT_START and WAIT_END.
- ram_rdata = src_rdata slice[gnt_id] when gnt_vld=1, else 0. This path is combinational with zero latency, so the engine's RAM read timing is preserved.
- src_addr = ram_addr, combinational.
- hspi_busy is ignored in IDLE, LAUNCH and GAP.

Optional Feature:
- Macro: HSPI_ARB_PRIO_EN.
- Defined: pending[0] has strict priority. If pending[0]=1 in IDLE, source 0 wins regardless of round-robin. last_gnt updates only on non-zero grants, so the rotation among sources 1..N-1 is preserved.
- Undefined: pure round-robin over all sources.

Test Plan:
- Single request: req=4'b0100 at cycle 0 → tx_act at cycle 2, gnt_id=2. Drive busy high for 100 cycles → done=4'b0100 one cycle after busy falls, err=0. With GAP_CYC=16, the next grant is no earlier than 17 cycles later.
- Fairness: req=4'b1111 pulse, busy 10 cycles per packet → grant order 0,1,2,3. Re-pulse req=4'b1001 → order 0,3 (last_gnt=3 wraps, so 0 is next, then 3).
- Timeout: TIMEOUT_CYC=50, busy never rises → done[gnt_id]=1 and err=1 exactly 50 cycles after entering WAIT_START; pending bit cleared.
- Re-request collision: req[1] pulsed in the same cycle as done[1] → pending[1] stays 1 and source 1 is granted again after the gap.
- Mux: gnt_id=3, src_rdata slice 3=32'hA5A5_0003 → ram_rdata=32'hA5A5_0003 in WAIT_END; ram_rdata=0 in IDLE.
- Reset mid-op: rstn low during WAIT_END → tx_act, gnt_vld, pending and done are all 0 immediately. After release, a req at cycle 0 → tx_act at cycle 2, source 0 first.
